// File: rtl/branch_target_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_target_predictor
// Description : Direct-mapped tagged branch target buffer with saturating
//               taken counters, whole-table flush and update statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_target_predictor #(
    parameter int PC_W  = 16,
    parameter int IDX_W = 10,
    parameter int TAG_W = 4,
    parameter int CTR_W = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PC_W-1:0]  lk_pc,
    output logic [PC_W-1:0]  pred_pc,
    output logic             pred_hit,
    input  logic             upd_valid,
    input  logic [PC_W-1:0]  upd_pc,
    input  logic             upd_taken,
    input  logic [PC_W-1:0]  upd_target,
    input  logic             upd_mispredict,
    input  logic             flush,
    output logic [CNT_W-1:0] upd_count,
    output logic [CNT_W-1:0] mis_count
);

    localparam int               c_depth    = 1 << IDX_W;
    localparam logic [CTR_W-1:0] c_ctr_max  = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] c_ctr_weak = CTR_W'(1) << (CTR_W - 1);

    generate
        if (IDX_W + TAG_W > PC_W - 1) begin : g_bad_params
            $error("branch_target_predictor: IDX_W+TAG_W must not exceed PC_W-1");
        end
    endgenerate

    logic [c_depth-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag    [c_depth];
    logic [PC_W-1:0]    r_target [c_depth];
    logic [CTR_W-1:0]   r_ctr    [c_depth];
    logic [CNT_W-1:0]   r_upd_count;
    logic [CNT_W-1:0]   r_mis_count;

    logic [IDX_W-1:0]   w_lk_idx;
    logic [TAG_W-1:0]   w_lk_tag;
    logic               w_lk_hit;
    logic [IDX_W-1:0]   w_up_idx;
    logic [TAG_W-1:0]   w_up_tag;
    logic               w_up_hit;
    logic               w_accept;
    logic               w_train;
    logic               w_alloc;
    logic [CTR_W-1:0]   w_ctr_cur;
    logic [CTR_W-1:0]   w_ctr_next;

    // PC bit 0 is always zero for 16-bit aligned instructions, so skip it.
    assign w_lk_idx = lk_pc[IDX_W:1];
    assign w_lk_tag = lk_pc[IDX_W+TAG_W:IDX_W+1];
    assign w_up_idx = upd_pc[IDX_W:1];
    assign w_up_tag = upd_pc[IDX_W+TAG_W:IDX_W+1];

    assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

    assign pred_hit = w_lk_hit;
    assign pred_pc  = (w_lk_hit && r_ctr[w_lk_idx][CTR_W-1]) ? r_target[w_lk_idx]
                                                              : lk_pc + PC_W'(2);

    assign w_accept = upd_valid && !flush;
    assign w_train  = w_accept && w_up_hit;
    assign w_alloc  = w_accept && !w_up_hit && upd_taken;

    assign w_ctr_cur = r_ctr[w_up_idx];

    always_comb begin
        w_ctr_next = w_ctr_cur;
        if (upd_taken) begin
            if (w_ctr_cur != c_ctr_max) w_ctr_next = w_ctr_cur + CTR_W'(1);
        end else begin
            if (w_ctr_cur != '0) w_ctr_next = w_ctr_cur - CTR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else if (flush) begin
            r_valid <= '0;
        end else if (w_alloc) begin
            r_valid[w_up_idx] <= 1'b1;
        end
    end

    // Payload arrays carry no reset. While rst is high every valid bit is
    // clear, so training cannot fire and an allocation only scribbles on an
    // invalid slot that the next real allocation fully rewrites.
    always_ff @(posedge clk) begin
        if (w_train) begin
            r_ctr[w_up_idx] <= w_ctr_next;
            if (upd_taken) r_target[w_up_idx] <= upd_target;
        end else if (w_alloc) begin
            r_tag[w_up_idx]    <= w_up_tag;
            r_target[w_up_idx] <= upd_target;
            r_ctr[w_up_idx]    <= c_ctr_weak;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_upd_count <= '0;
            r_mis_count <= '0;
        end else if (w_accept) begin
            r_upd_count <= r_upd_count + CNT_W'(1);
            if (upd_mispredict) r_mis_count <= r_mis_count + CNT_W'(1);
        end
    end

    assign upd_count = r_upd_count;
    assign mis_count = r_mis_count;

endmodule
`default_nettype wire

// File: tb/tb_branch_target_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_target_predictor
// Description : Directed self-checking bench for branch_target_predictor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_target_predictor;

    localparam int PC_W  = 16;
    localparam int IDX_W = 10;
    localparam int TAG_W = 4;
    localparam int CTR_W = 2;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [PC_W-1:0]  lk_pc;
    logic [PC_W-1:0]  pred_pc;
    logic             pred_hit;
    logic             upd_valid;
    logic [PC_W-1:0]  upd_pc;
    logic             upd_taken;
    logic [PC_W-1:0]  upd_target;
    logic             upd_mispredict;
    logic             flush;
    logic [CNT_W-1:0] upd_count;
    logic [CNT_W-1:0] mis_count;

    int n_tests = 0;
    int n_fail  = 0;

    branch_target_predictor #(
        .PC_W (PC_W),
        .IDX_W(IDX_W),
        .TAG_W(TAG_W),
        .CTR_W(CTR_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .lk_pc         (lk_pc),
        .pred_pc       (pred_pc),
        .pred_hit      (pred_hit),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .upd_taken     (upd_taken),
        .upd_target    (upd_target),
        .upd_mispredict(upd_mispredict),
        .flush         (flush),
        .upd_count     (upd_count),
        .mis_count     (mis_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // At most three lookups between edges (each advances 1 ns).
    task automatic look(input string tag, input logic [PC_W-1:0] pc,
                        input logic exp_hit, input logic [PC_W-1:0] exp_pc);
        lk_pc = pc;
        #1;
        check({tag, "_hit"}, 32'(pred_hit), 32'(exp_hit));
        check({tag, "_pc"},  32'(pred_pc),  32'(exp_pc));
    endtask

    task automatic counts(input string tag, input int exp_u, input int exp_m);
        check({tag, "_upd"}, 32'(upd_count), 32'(exp_u));
        check({tag, "_mis"}, 32'(mis_count), 32'(exp_m));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [PC_W-1:0] pc, input logic taken,
                       input logic [PC_W-1:0] tgt, input logic misp, input logic fl);
        upd_valid      = 1'b1;
        upd_pc         = pc;
        upd_taken      = taken;
        upd_target     = tgt;
        upd_mispredict = misp;
        flush          = fl;
        tick();
        upd_valid      = 1'b0;
        upd_mispredict = 1'b0;
        flush          = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        lk_pc          = 16'h0010;
        upd_valid      = 1'b0;
        upd_pc         = '0;
        upd_taken      = 1'b0;
        upd_target     = '0;
        upd_mispredict = 1'b0;
        flush          = 1'b0;

        // Update held across edges during reset must be discarded.
        upd_valid  = 1'b1;
        upd_pc     = 16'h0010;
        upd_taken  = 1'b1;
        upd_target = 16'h0400;
        upd_mispredict = 1'b1;
        tick();
        tick();
        upd_valid = 1'b0;
        upd_mispredict = 1'b0;
        rst = 1'b0;
        tick();

        look("reset", 16'h0010, 1'b0, 16'h0012);
        counts("reset", 0, 0);

        // Allocate: weakly taken, target 0x0400.
        upd(16'h0010, 1'b1, 16'h0400, 1'b1, 1'b0);
        look("alloc", 16'h0010, 1'b1, 16'h0400);
        counts("alloc", 1, 1);

        // Counter 2 -> 1 -> 0 -> 0 (saturates low).
        upd(16'h0010, 1'b0, 16'h0000, 1'b0, 1'b0);
        look("nt1", 16'h0010, 1'b1, 16'h0012);
        upd(16'h0010, 1'b0, 16'h0000, 1'b1, 1'b0);
        look("nt2", 16'h0010, 1'b1, 16'h0012);
        upd(16'h0010, 1'b0, 16'h0000, 1'b0, 1'b0);
        // 0 -> 1: still predicts fall-through, target rewritten to 0x0402.
        upd(16'h0010, 1'b1, 16'h0402, 1'b0, 1'b0);
        look("t1", 16'h0010, 1'b1, 16'h0012);
        // 1 -> 2: taken, new target visible.
        upd(16'h0010, 1'b1, 16'h0404, 1'b0, 1'b0);
        look("t2", 16'h0010, 1'b1, 16'h0404);
        // 2 -> 3 -> 3 (saturates high), then 3 -> 2 still taken, 2 -> 1 not.
        upd(16'h0010, 1'b1, 16'h0404, 1'b0, 1'b0);
        upd(16'h0010, 1'b1, 16'h0404, 1'b0, 1'b0);
        upd(16'h0010, 1'b0, 16'h0000, 1'b0, 1'b0);
        look("sat_nt1", 16'h0010, 1'b1, 16'h0404);
        upd(16'h0010, 1'b0, 16'h0000, 1'b0, 1'b0);
        look("sat_nt2", 16'h0010, 1'b1, 16'h0012);
        counts("train", 10, 2);

        // Not-taken miss leaves the table alone but is still counted.
        upd(16'h0020, 1'b0, 16'h0700, 1'b0, 1'b0);
        look("nt_miss", 16'h0020, 1'b0, 16'h0022);
        counts("nt_miss", 11, 2);

        // Same-cycle update is not bypassed to the lookup.
        upd_valid  = 1'b1;
        upd_pc     = 16'h0030;
        upd_taken  = 1'b1;
        upd_target = 16'h0500;
        look("nobypass", 16'h0030, 1'b0, 16'h0032);
        tick();
        upd_valid = 1'b0;
        look("after_wr", 16'h0030, 1'b1, 16'h0500);
        counts("after_wr", 12, 2);

        // Alias: same index, different tag replaces the entry.
        upd(16'h0810, 1'b1, 16'h0200, 1'b0, 1'b0);
        look("alias_old", 16'h0010, 1'b0, 16'h0012);
        look("alias_new", 16'h0810, 1'b1, 16'h0200);

        // Flush wins over a simultaneous update.
        upd(16'h0040, 1'b1, 16'h0600, 1'b1, 1'b1);
        look("fl_0810", 16'h0810, 1'b0, 16'h0812);
        look("fl_0030", 16'h0030, 1'b0, 16'h0032);
        look("fl_0040", 16'h0040, 1'b0, 16'h0042);
        counts("flush", 13, 2);
        tick();
        look("wrap_pc", 16'hFFFE, 1'b0, 16'h0000);

        // Asynchronous reset pulse between edges clears counts at once.
        tick();
        rst = 1'b1;
        #1;
        counts("arst1", 0, 0);
        rst = 1'b0;

        for (int i = 0; i < (1 << CNT_W) - 1; i++)
            upd(16'h0050, 1'b1, 16'h0800, 1'b1, 1'b0);
        counts("pre_wrap", (1 << CNT_W) - 1, (1 << CNT_W) - 1);
        upd(16'h0050, 1'b1, 16'h0800, 1'b1, 1'b0);
        counts("wrap", 0, 0);
        for (int i = 0; i < 3; i++)
            upd(16'h0050, 1'b1, 16'h0800, 1'b1, 1'b0);
        counts("post_wrap", 3, 3);
        look("pre_arst", 16'h0050, 1'b1, 16'h0800);

        rst = 1'b1;
        #1;
        counts("arst2", 0, 0);
        look("arst2", 16'h0050, 1'b0, 16'h0052);
        rst = 1'b0;
        tick();
        counts("arst2_rel", 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
